// File: rtl/instr_mem_pl.sv
// Registered-read instruction memory for the fetch stage: valid/ready fetch port,
// back-pressure hold, branch flush, bootload write port and fetch fault reporting.
module instr_mem_pl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         DEPTH         = 1024,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
    parameter logic [DATA_WIDTH-1:0]      NOP_INSTR     = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_prog_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_prog_addr,
    input  logic [DATA_WIDTH-1:0]     i_prog_data,
    input  logic                      i_flush,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_addr,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_instr,
    output logic [ADDRESS_WIDTH-1:0]  o_rsp_addr,
    output logic [1:0]                o_rsp_fault
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LSB_MASK = ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_W  = ADDRESS_WIDTH'(DEPTH);

    // {out_of_range, misaligned}; offset wraps modulo 2^ADDRESS_WIDTH so addresses below BASE_ADDR land out of range
    function automatic logic [1:0] f_fault(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return {((off >> LSB) >= DEPTH_W), |(off & LSB_MASK)};
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> LSB);
    endfunction

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_valid;
    logic                     r_nop;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [1:0]               r_fault;

    logic [1:0]               w_req_fault;
    logic [1:0]               w_prog_fault;
    logic [IDX_W-1:0]         w_req_idx;
    logic [IDX_W-1:0]         w_prog_idx;
    logic                     w_req_ready;
    logic                     w_accept;

    assign w_req_fault  = f_fault(i_req_addr);
    assign w_prog_fault = f_fault(i_prog_addr);
    assign w_req_idx    = f_index(i_req_addr);
    assign w_prog_idx   = f_index(i_prog_addr);
    assign w_req_ready  = !i_prog_we && !i_flush && (!r_valid || i_rsp_ready);
    assign w_accept     = i_req_valid && w_req_ready;

    // Array and read register carry no reset so the pair maps onto block RAM.
    // Read register only loads on accept, which keeps the word stable during a hold.
    always_ff @(posedge clk) begin
        if (i_prog_we && (w_prog_fault == 2'b00)) begin
            r_mem[w_prog_idx] <= i_prog_data;
        end
        if (w_accept) begin
            r_rdata <= r_mem[w_req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_nop   <= 1'b1;
            r_addr  <= '0;
            r_fault <= 2'b00;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_nop   <= (w_req_fault != 2'b00);
            r_addr  <= i_req_addr;
            r_fault <= w_req_fault;
        end else if (i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    // r_nop substitutes NOP_INSTR for faulted fetches and for the undefined RAM output after reset
    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = r_valid;
    assign o_rsp_instr = r_nop ? NOP_INSTR : r_rdata;
    assign o_rsp_addr  = r_addr;
    assign o_rsp_fault = r_fault;

endmodule
